// File: rtl/pool_pkg.sv
// Shared definitions for the pooling stream: mode encoding, FSM state type,
// default pixel width and accumulator sizing helpers.
package pool_pkg;

  localparam int DEFAULT_DATA_W = 16;

  localparam logic POOL_AVG = 1'b0;
  localparam logic POOL_MAX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Right shift that turns a POOL*POOL window sum into its average.
  function automatic int pool_shift(input int pool);
    return 2 * $clog2(pool);
  endfunction

  // Window accumulator width: wide enough that a full window sum never overflows.
  function automatic int acc_width(input int data_w, input int pool);
    return data_w + pool_shift(pool);
  endfunction

endpackage

// File: rtl/pool_lane.sv
// Per-pixel window datapath: load, accumulate or compare one pixel into a
// window entry and produce the scaled pooled result from the updated entry.
// Max pooling is only built when POOL_MAX_EN is defined; otherwise the lane
// averages and the mode input is ignored.
module pool_lane
  import pool_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int POOL   = 2,
  parameter int ACC_W  = acc_width(DATA_W, POOL)
) (
  input  logic [ACC_W-1:0]  acc_in,
  input  logic [DATA_W-1:0] pixel,
  input  logic              load,
  input  logic              mode,
  output logic [ACC_W-1:0]  acc_out,
  output logic [DATA_W-1:0] result
);

  localparam int SHIFT = pool_shift(POOL);

  logic signed [ACC_W-1:0] acc_s;
  logic signed [ACC_W-1:0] pix_s;
  logic signed [ACC_W-1:0] next_s;

  assign acc_s = acc_in;
  assign pix_s = {{(ACC_W-DATA_W){pixel[DATA_W-1]}}, pixel};

`ifndef POOL_MAX_EN
  logic mode_unused;
  assign mode_unused = mode;
`endif

  // Fold the pixel into the entry, then derive the pooled value from it.
  always_comb begin
    next_s = acc_s + pix_s;
`ifdef POOL_MAX_EN
    if (mode == POOL_MAX) next_s = (pix_s > acc_s) ? pix_s : acc_s;
`endif
    if (load) next_s = pix_s;
    acc_out = next_s;
    // Arithmetic shift floors toward minus infinity.
    result = DATA_W'(next_s >>> SHIFT);
`ifdef POOL_MAX_EN
    if (mode == POOL_MAX) result = next_s[DATA_W-1:0];
`endif
  end

endmodule

// File: rtl/pooling_stream.sv
// Streaming POOLxPOOL pooling over a row-major image. One line buffer entry
// per window column collects the window while rows stream past; the result
// lands in a single output register (no skid buffer).
// Optional feature macro: POOL_MAX_EN enables max pooling selected by mode.
module pooling_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int POOL   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pixel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pixel,
  output logic              busy,
  output logic              finish
);

  localparam int ACC_W = acc_width(DATA_W, POOL);
  localparam int LOG_P = $clog2(POOL);
  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int NE    = IMG_W / POOL;
  localparam int IW    = (NE > 1) ? $clog2(NE) : 1;

  generate
    if (!(POOL == 2 || POOL == 4) || (IMG_W % POOL) != 0 || (IMG_H % POOL) != 0) begin : g_bad_cfg
      $error("pooling_stream: POOL must be 2 or 4 and must divide IMG_W and IMG_H");
    end
  endgenerate

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              mode_q, mode_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_pixel_q, out_pixel_d;
  logic              last_out_q, last_out_d;
  logic              busy_q, busy_d;
  logic              finish_q, finish_d;

  logic [ACC_W-1:0]  line_q [2**IW];
  logic [IW-1:0]     ent_idx;
  logic [ACC_W-1:0]  ent_d;
  logic [DATA_W-1:0] lane_result;

  logic in_fire, out_fire, win_first, win_last, frame_last;

`ifndef POOL_MAX_EN
  logic mode_unused;
  assign mode_unused = mode;
`endif

  assign in_ready   = (state_q == ST_RUN) && (!out_valid_q || out_ready);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid_q && out_ready;
  assign ent_idx    = IW'(col_q >> LOG_P);
  assign win_first  = (col_q[LOG_P-1:0] == '0) && (row_q[LOG_P-1:0] == '0);
  assign win_last   = (&col_q[LOG_P-1:0]) && (&row_q[LOG_P-1:0]);
  assign frame_last = (col_q == CW'(IMG_W-1)) && (row_q == RW'(IMG_H-1));

  pool_lane #(
    .DATA_W (DATA_W),
    .POOL   (POOL),
    .ACC_W  (ACC_W)
  ) u_lane (
    .acc_in  (line_q[ent_idx]),
    .pixel   (in_pixel),
    .load    (win_first),
    .mode    (mode_q),
    .acc_out (ent_d),
    .result  (lane_result)
  );

  // Next-state, counter and output-register decisions for the frame FSM.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    last_out_d  = last_out_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RUN;
          col_d      = '0;
          row_d      = '0;
          last_out_d = 1'b0;
`ifdef POOL_MAX_EN
          mode_d     = mode;
`else
          mode_d     = POOL_AVG;
`endif
        end
      end
      ST_RUN: begin
        if (out_fire) begin
          out_valid_d = 1'b0;
          if (last_out_q) begin
            state_d    = ST_DONE;
            last_out_d = 1'b0;
          end
        end
        if (in_fire) begin
          if (col_q == CW'(IMG_W-1)) begin
            col_d = '0;
            row_d = (row_q == RW'(IMG_H-1)) ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          // Window just completed: its result takes the output register.
          if (win_last) begin
            out_valid_d = 1'b1;
            out_pixel_d = lane_result;
            last_out_d  = frame_last;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d   = (state_d == ST_RUN);
    finish_d = (state_d == ST_DONE);
  end

  // Control and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= POOL_AVG;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      last_out_q  <= 1'b0;
      busy_q      <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      last_out_q  <= last_out_d;
      busy_q      <= busy_d;
      finish_q    <= finish_d;
    end
  end

  // Line buffer update: every accepted pixel rewrites its window entry.
  always_ff @(posedge clk) begin
    if (in_fire) line_q[ent_idx] <= ent_d;
  end

  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign busy      = busy_q;
  assign finish    = finish_q;

endmodule
